// File: rtl/da_pkg.sv
// Shared types and width helpers for the bit-serial OBC distributed-arithmetic FIR.
package da_pkg;

    typedef enum logic [1:0] {
        S_BUILD = 2'd0,
        S_READY = 2'd1,
        S_MAC   = 2'd2,
        S_DONE  = 2'd3
    } da_state_e;

    function automatic int tw_f(input int ww, input int taps);
        return ww + $clog2(taps);
    endfunction

    function automatic int ow_f(input int xw, input int ww, input int taps);
        return xw + ww + $clog2(taps);
    endfunction

endpackage

// File: rtl/da_obc_lut.sv
// Offset-binary half-size LUT: shadow weights, one-entry-per-cycle builder, async read port.
module da_obc_lut
    import da_pkg::*;
#(
    parameter int TAPS = 4,
    parameter int WW   = 10,
    parameter int TW   = WW + $clog2(TAPS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [TAPS*WW-1:0]       coef_i,
    input  logic                     load_i,
    input  logic                     build_i,
    input  logic [TAPS-2:0]          addr_i,
    output logic signed [TW-1:0]     t_o,
    output logic signed [TW-1:0]     t0_o,
    output logic                     build_done_o
);
    localparam int DEPTH = 2 ** (TAPS - 1);

    logic signed [WW-1:0] w_q   [TAPS];
    logic signed [TW-1:0] lut_q [DEPTH];
    logic [TAPS-2:0]      cnt_q;
    logic signed [TW-1:0] entry;

    // Address bit k-1 set means tap k disagrees with tap 0, so its weight enters negated.
    always_comb begin
        entry = TW'(w_q[0]);
        for (int k = 1; k < TAPS; k++) begin
            entry = cnt_q[k-1] ? entry - TW'(w_q[k]) : entry + TW'(w_q[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            for (int k = 0; k < TAPS; k++) w_q[k] <= '0;
            for (int a = 0; a < DEPTH; a++) lut_q[a] <= '0;
        end else begin
            if (build_i) lut_q[cnt_q] <= entry;
            if (load_i) begin
                cnt_q <= '0;
                for (int k = 0; k < TAPS; k++) w_q[k] <= coef_i[k*WW +: WW];
            end else if (build_i) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign build_done_o = build_i && (cnt_q == '1);
    assign t_o          = lut_q[addr_i];
    assign t0_o         = lut_q[0];

endmodule

// File: rtl/da_obc_fir_serial.sv
// Bit-serial OBC distributed-arithmetic FIR: FSM, delay line, MSB-first Horner accumulator.
module da_obc_fir_serial
    import da_pkg::*;
#(
    parameter int TAPS = 4,
    parameter int XW   = 8,
    parameter int WW   = 10
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [TAPS*WW-1:0]                   coef,
    input  logic                                 coef_load,
    input  logic signed [XW-1:0]                 in_data,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    output logic signed [XW+WW+$clog2(TAPS)-1:0] out_data,
    output logic                                 out_valid,
    output logic                                 busy
);
    localparam int TW = tw_f(WW, TAPS);
    localparam int OW = ow_f(XW, WW, TAPS);
    localparam int AW = OW + 1;
    localparam int JW = (XW > 2) ? $clog2(XW) : 1;

    da_state_e            state_q, state_d;
    logic                 pend_q, pend_d;
    logic signed [XW-1:0] x_q [TAPS];
    logic [JW-1:0]        j_q;
    logic signed [AW-1:0] acc_q;
    logic signed [OW-1:0] out_data_q;
    logic                 out_valid_q;

    logic [TAPS-2:0]      addr;
    logic                 sgn;
    logic signed [TW-1:0] t_rd, t0;
    logic signed [AW-1:0] t_ext, q_val, diff;
    logic                 build_done;
    logic                 accept;

    da_obc_lut #(.TAPS(TAPS), .WW(WW), .TW(TW)) u_lut (
        .clk          (clk),
        .rst_n        (rst_n),
        .coef_i       (coef),
        .load_i       (coef_load),
        .build_i      (state_q == S_BUILD),
        .addr_i       (addr),
        .t_o          (t_rd),
        .t0_o         (t0),
        .build_done_o (build_done)
    );

    assign accept = (state_q == S_READY) && in_valid;

    // The sample's sign bit carries negative weight, hence the inverted select at the MSB.
    always_comb begin
        addr = '0;
        for (int k = 1; k < TAPS; k++) addr[k-1] = x_q[0][j_q] ^ x_q[k][j_q];
        sgn   = x_q[0][j_q] ^ (j_q == JW'(XW - 1));
        t_ext = AW'(t_rd);
        q_val = sgn ? t_ext : -t_ext;
        diff  = acc_q - AW'(t0);
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        case (state_q)
            S_BUILD: begin
                pend_d = 1'b0;
                if (!coef_load && build_done) state_d = S_READY;
            end
            S_READY: begin
                if (in_valid) begin
                    state_d = S_MAC;
                    pend_d  = coef_load;
                end else if (coef_load) begin
                    state_d = S_BUILD;
                end
            end
            S_MAC: begin
                if (coef_load) pend_d = 1'b1;
                if (j_q == '0) state_d = S_DONE;
            end
            default: begin
                pend_d  = 1'b0;
                state_d = (pend_q || coef_load) ? S_BUILD : S_READY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_BUILD;
            pend_q      <= 1'b0;
            j_q         <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            for (int k = 0; k < TAPS; k++) x_q[k] <= '0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            out_valid_q <= (state_q == S_DONE);
            if (accept) begin
                x_q[0] <= in_data;
                for (int k = 1; k < TAPS; k++) x_q[k] <= x_q[k-1];
                acc_q <= '0;
                j_q   <= JW'(XW - 1);
            end
            if (state_q == S_MAC) begin
                acc_q <= (acc_q <<< 1) + q_val;
                j_q   <= j_q - JW'(1);
            end
            // acc - T[0] is always even, so the shift is exact.
            if (state_q == S_DONE) out_data_q <= OW'(diff >>> 1);
        end
    end

    assign in_ready  = (state_q == S_READY);
    assign busy      = (state_q == S_BUILD) || (state_q == S_MAC);
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_da_obc_fir_serial.sv
// Directed and randomised bench for da_obc_fir_serial against an integer FIR model.
module tb_da_obc_fir_serial;
    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [39:0]        coef = '0;
    logic               coef_load = 1'b0;
    logic signed [7:0]  in_data = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [19:0] out_data;
    logic               out_valid;
    logic               busy;

    da_obc_fir_serial #(.TAPS(4), .XW(8), .WW(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .coef      (coef),
        .coef_load (coef_load),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;
    int mw [4];
    int nw [4];
    int hist [4];
    int exp_q [$];
    int accc_q [$];
    int out_log [$];
    int last_acc = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        int e, a;
        if (rst_n && out_valid) begin
            nvec++;
            out_log.push_back(int'(out_data));
            if (exp_q.size() == 0) begin
                nerr++;
                $display("FAIL spurious_out_valid: out_data=%0d, no result was due", out_data);
            end else begin
                e = exp_q.pop_front();
                a = accc_q.pop_front();
                if (int'(out_data) != e) begin
                    nerr++;
                    $display("FAIL out_data: got %0d required %0d", out_data, e);
                end
                if (cyc - a != 10) begin
                    nerr++;
                    $display("FAIL latency: got %0d required 10", cyc - a);
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int want);
        nvec++;
        if (got != want) begin
            nerr++;
            $display("FAIL %s: got %0d required %0d", name, got, want);
        end
    endtask

    task automatic drive_coef();
        int t;
        for (int k = 0; k < 4; k++) begin
            t = nw[k];
            coef[k*10 +: 10] = t[9:0];
        end
        coef_load = 1'b1;
        mw = nw;
    endtask

    task automatic set_w(input int a, input int b, input int c, input int d);
        nw = '{a, b, c, d};
        drive_coef();
        @(negedge clk);
        coef_load = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        mw = '{0, 0, 0, 0};
        hist = '{0, 0, 0, 0};
        exp_q.delete();
        accc_q.delete();
    endtask

    // Offer x (held while busy); ld<0: no reload, ld=0: reload at accept, ld>0: ld cycles later.
    task automatic send(input int x, input int ld);
        int tmo, y, t;
        t = x;
        in_data  = t[7:0];
        in_valid = 1'b1;
        tmo = 0;
        while (!in_ready && tmo < 100) begin
            @(negedge clk);
            tmo++;
        end
        if (!in_ready) begin
            nvec++;
            nerr++;
            $display("FAIL ready_timeout: in_ready still 0 after %0d cycles, required 1", tmo);
            in_valid = 1'b0;
            return;
        end
        for (int k = 3; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = x;
        y = 0;
        for (int k = 0; k < 4; k++) y += mw[k] * hist[k];
        exp_q.push_back(y);
        accc_q.push_back(cyc);
        last_acc = cyc;
        if (ld == 0) drive_coef();
        @(negedge clk);
        in_valid  = 1'b0;
        coef_load = 1'b0;
        if (ld > 0) begin
            repeat (ld - 1) @(negedge clk);
            drive_coef();
            @(negedge clk);
            coef_load = 1'b0;
        end
    endtask

    task automatic drain();
        int tmo;
        tmo = 0;
        while (exp_q.size() != 0 && tmo < 60) begin
            @(negedge clk);
            tmo++;
        end
        check("drain_pending", exp_q.size(), 0);
    endtask

    initial begin
        int n, prev, x, ld;
        // Reset and first build
        @(negedge clk);
        do_reset();
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_busy", int'(busy), 1);
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("build_cycles", n, 8);
        check("ready_busy", int'(busy), 0);

        // Impulse response
        set_w(1, 2, 3, 4);
        out_log.delete();
        send(1, -1);
        check("mac_busy", int'(busy), 1);
        send(0, -1);
        send(0, -1);
        send(0, -1);
        drain();
        check("impulse_len", out_log.size(), 4);
        if (out_log.size() == 4) begin
            check("impulse_y0", out_log[0], 1);
            check("impulse_y1", out_log[1], 2);
            check("impulse_y2", out_log[2], 3);
            check("impulse_y3", out_log[3], 4);
        end

        // Full-scale extremes
        set_w(511, 511, 511, 511);
        out_log.delete();
        send(-128, -1);
        prev = last_acc;
        send(-128, -1);
        check("b2b_spacing", last_acc - prev, 10);
        send(-128, -1);
        send(-128, -1);
        drain();
        if (out_log.size() == 4) check("ext_pos_w", out_log[3], -261632);
        else check("ext_pos_len", out_log.size(), 4);
        set_w(-512, -512, -512, -512);
        out_log.delete();
        send(-128, -1);
        drain();
        if (out_log.size() == 1) check("ext_neg_w", out_log[0], 262144);
        else check("ext_neg_len", out_log.size(), 1);

        // Reload during MAC: old weights for in-flight sample, then rebuild
        out_log.delete();
        nw = '{5, 0, 0, 0};
        send(0, 3);
        prev = last_acc;
        send(-3, -1);
        check("reload_spacing", last_acc - prev, 18);
        drain();
        if (out_log.size() == 2) begin
            check("reload_old_w", out_log[0], 196608);
            check("reload_new_w", out_log[1], -15);
        end else check("reload_len", out_log.size(), 2);

        // Reset in the middle of MAC
        set_w(1, 1, 1, 1);
        send(100, -1);
        send(7, -1);
        repeat (3) @(negedge clk);
        do_reset();
        out_log.delete();
        repeat (15) @(negedge clk);
        check("midmac_no_out", out_log.size(), 0);
        set_w(1, 1, 1, 1);
        send(0, -1);
        drain();
        if (out_log.size() == 1) check("midmac_line_zero", out_log[0], 0);
        else check("midmac_len", out_log.size(), 1);

        // Randomised samples and reload timing
        for (int i = 0; i < 3000; i++) begin
            x  = int'($urandom_range(255)) - 128;
            ld = ($urandom_range(9) < 7) ? -1 : int'($urandom_range(11));
            if (ld >= 0) begin
                for (int k = 0; k < 4; k++) begin
                    nw[k] = ($urandom_range(15) == 0) ? -512 : int'($urandom_range(1023)) - 512;
                end
            end
            send(x, ld);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
